// File: rtl/exec_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exec_sequencer : multi-cycle fetch / decode / execute / write-back control
//                  for the regfile + combinational ALU datapath.
//                  Optional macro SEQ_RETIRE_CNT_EN adds the `retired` counter.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module exec_sequencer #(
    parameter int              N        = 32,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rf_raddr_a,
    output logic [4:0]      rf_raddr_b,
    input  logic [N-1:0]    rf_rdata_a,
    input  logic [N-1:0]    rf_rdata_b,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [13:0]     alu_op,
    input  logic [N-1:0]    alu_result,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [N-1:0]    rf_wdata,
`ifdef SEQ_RETIRE_CNT_EN
    output logic [31:0]     retired,
`endif
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [N-1:0]    res_q;
    logic [N-1:0]    alu_a_q;
    logic [N-1:0]    alu_b_q;
    logic            imem_req_q;
    logic            rf_we_q;
    logic            illegal_q;

    logic [6:0]      opcode;
    logic            is_r;
    logic            is_i;
    logic [N-1:0]    imm_sext;
    logic [N-1:0]    alu_a_d;
    logic [N-1:0]    alu_b_d;
    logic            unused_funct3;

    assign opcode        = ir_q[6:0];
    assign is_r          = (opcode == OP_R);
    assign is_i          = (opcode == OP_I);
    assign imm_sext      = {{(N-12){ir_q[31]}}, ir_q[31:20]};
    assign alu_a_d       = rf_rdata_a;
    assign alu_b_d       = is_r ? rf_rdata_b : imm_sext;
    // funct3 is not part of the ALU opcode handed to the datapath
    assign unused_funct3 = ^ir_q[14:12];

`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0] retired_q;
    assign retired = retired_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            res_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            imem_req_q <= 1'b0;
            rf_we_q    <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
            retired_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_SYS) begin
                        state_q <= S_HALT;
                    end else if (!is_r && !is_i) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_WB;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_a_q <= alu_a_d;
                    alu_b_q <= alu_b_d;
                    res_q   <= alu_result;
                    rf_we_q <= (ir_q[11:7] != 5'd0);
                    state_q <= S_WB;
                end
                S_WB: begin
                    rf_we_q <= 1'b0;
                    pc_q    <= pc_q + PC_W'(4);
`ifdef SEQ_RETIRE_CNT_EN
                    if (is_r || is_i) begin
                        retired_q <= retired_q + 32'd1;
                    end
`endif
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ALU operands follow the register file live during EXEC and hold afterwards
    assign alu_a      = (state_q == S_EXEC) ? alu_a_d : alu_a_q;
    assign alu_b      = (state_q == S_EXEC) ? alu_b_d : alu_b_q;
    assign alu_op     = {ir_q[31:25], ir_q[6:0]};
    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign rf_raddr_a = ir_q[19:15];
    assign rf_raddr_b = ir_q[24:20];
    assign rf_we      = rf_we_q;
    assign rf_waddr   = ir_q[11:7];
    assign rf_wdata   = res_q;
    assign pc         = pc_q;
    assign busy       = (state_q != S_IDLE);
    assign illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// tb_exec_sequencer : randomized scoreboard bench for exec_sequencer with an
//                     instruction-level reference model, regfile and ALU models.
module tb_exec_sequencer;

    localparam logic [15:0] RESET_PC = 16'hFFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_raddr_a;
    logic [4:0]  rf_raddr_b;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [13:0] alu_op;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] pc;
    logic        busy;
    logic        illegal;
`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    exec_sequencer #(.N(32), .PC_W(16), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
`ifdef SEQ_RETIRE_CNT_EN
        .retired    (retired),
`endif
        .pc         (pc),
        .busy       (busy),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Environment ALU: subtract when funct7 is 0x20, otherwise add.
    function automatic logic [31:0] alu_fn(input logic [13:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op[13:7] == 7'h20) ? (a - b) : (a + b);
    endfunction
    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    // Environment register file: registered read, x0 never written, backdoor preset port.
    logic [31:0] rf [32];
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        bd_we = 1'b0;
    logic [4:0]  bd_addr = 5'd0;
    logic [31:0] bd_data = 32'd0;
    always @(posedge clk) begin
        rd_a <= rf[rf_raddr_a];
        rd_b <= rf[rf_raddr_b];
        if (bd_we) rf[bd_addr] <= bd_data;
        else if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata_a = rd_a;
    assign rf_rdata_b = rd_b;

    // Instruction memory and reference-model state
    logic [31:0] mem [16384];
    logic [31:0] ref_rf [32];
    logic [31:0] prog_q [$];
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [13:0] op;
    } exp_t;
    exp_t exp_q [$];

    logic [15:0] m_pc;
    logic        m_ill;
    logic        m_halt;
    logic [31:0] m_ret;
    int          m_fetch;
    int          n_fetch = 0;
    int          fixed_delay = 0;
    int          start_cyc = 0;
    bit          lat_chk = 1'b0;
    int          lat_exp = 0;

    // Instruction memory responder: programmable wait states, noise while not requested.
    initial begin
        int          wait_cnt;
        int          cur_delay;
        logic [15:0] held;
        wait_cnt = 0; cur_delay = 0; held = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem_req && !rst) begin
                check("imem_addr_eq_pc", imem_addr, pc);
                if (wait_cnt == 0) held = imem_addr;
                else check("imem_addr_stable", imem_addr, held);
                if (wait_cnt == cur_delay) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem[imem_addr[15:2]];
                    n_fetch++;
                end else begin
                    imem_valid = 1'b0;
                end
                wait_cnt++;
            end else begin
                imem_valid = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
                wait_cnt   = 0;
                cur_delay  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end
        end
    end

    // Scoreboard monitor: every write-back pops one expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rf_we) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_wb: got waddr=%0d wdata=%0h, expected no write", rf_waddr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_addr", rf_waddr, e.addr);
                    check("wb_data", rf_wdata, e.data);
                    check("wb_alu_op", alu_op, e.op);
                    if (lat_chk) begin
                        check("wb_latency", cyc - start_cyc, lat_exp);
                        lat_chk = 1'b0;
                    end
                end
            end
        end
    end

    task automatic model_reset();
        m_pc = RESET_PC; m_ill = 1'b0; m_halt = 1'b0; m_ret = '0; m_fetch = 0;
        exp_q.delete();
    endtask

    // Instruction-level model: executes up to max_instr instructions from m_pc.
    task automatic model_run(input int max_instr);
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        exp_t        e;
        for (int k = 0; k < max_instr && !m_halt; k++) begin
            ins = mem[m_pc[15:2]];
            m_fetch++;
            if (ins[6:0] == 7'h73) begin
                m_halt = 1'b1;
            end else if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
                a = ref_rf[ins[19:15]];
                b = (ins[6:0] == 7'h33) ? ref_rf[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
                r = alu_fn({ins[31:25], ins[6:0]}, a, b);
                if (ins[11:7] != 5'd0) begin
                    ref_rf[ins[11:7]] = r;
                    e.addr = ins[11:7]; e.data = r; e.op = {ins[31:25], ins[6:0]};
                    exp_q.push_back(e);
                end
                m_ret = m_ret + 32'd1;
                m_pc  = m_pc + 16'd4;
            end else begin
                m_ill = 1'b1;
                m_pc  = m_pc + 16'd4;
            end
        end
    endtask

    task automatic load_prog();
        logic [15:0] a;
        for (int i = 0; i < prog_q.size(); i++) begin
            a = RESET_PC + 16'(4 * i);
            mem[a[15:2]] = prog_q[i];
        end
    endtask

    task automatic preset(input int idx, input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 5'(idx); bd_data = v;
        ref_rf[idx] = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fetches(input int target);
        int budget;
        budget = 100 * target + 50;
        while (n_fetch < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("fetch_count", n_fetch, target);
    endtask

    task automatic check_halt();
        check("halt_busy", busy, 1'b1);
        check("halt_req", imem_req, 1'b0);
        check("halt_pc", pc, m_pc);
        check("illegal", illegal, m_ill);
        check("scoreboard_empty", exp_q.size(), 0);
`ifdef SEQ_RETIRE_CNT_EN
        check("retired", retired, m_ret);
`endif
        pulse_start();
        repeat (6) @(negedge clk);
        check("halt_ignores_start_busy", busy, 1'b1);
        check("halt_ignores_start_fetch", n_fetch, m_fetch);
        check("halt_ignores_start_pc", pc, m_pc);
    endtask

    task automatic run_to_halt();
        n_fetch = 0; m_fetch = 0;
        load_prog();
        model_run(1000);
        pulse_start();
        wait_fetches(m_fetch);
        repeat (4) @(negedge clk);
        check_halt();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd;
        logic [11:0] imm;
        logic [6:0]  bad [6];
        bad[0] = 7'h7F; bad[1] = 7'h03; bad[2] = 7'h23; bad[3] = 7'h63; bad[4] = 7'h37; bad[5] = 7'h00;
        rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 8: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 5'($urandom), 5'($urandom), 3'b000, rd, 7'h33};
            4, 5, 6:       return {imm, 5'($urandom), 3'b000, rd, 7'h13};
            default:       return {25'($urandom), bad[$urandom_range(0, 5)]};
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        check("rst_busy", busy, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_we", rf_we, 1'b0);
        check("rst_pc", pc, RESET_PC);
        check("rst_illegal", illegal, 1'b0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", alu_op, 14'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_waddr", rf_waddr, 5'd0);
`ifdef SEQ_RETIRE_CNT_EN
        check("rst_retired", retired, 32'd0);
`endif

        for (int i = 0; i < 32; i++) preset(i, (i == 0) ? 32'd0 : $urandom);
        preset(1, 32'd5);
        preset(2, 32'd7);

        // add x3,x1,x2 with a zero-wait fetch: write-back 4 cycles after start
        fixed_delay = 0;
        prog_q = {32'h002081B3, 32'h00000073};
        lat_chk = 1'b1; lat_exp = 4;
        run_to_halt();
        do_reset();

        // addi x5,x0,-1 then ecall
        prog_q = {32'hFFF00293, 32'h00000073};
        run_to_halt();
        do_reset();

        // write to x0: no write strobe, still retires
        prog_q = {32'h00208033, 32'h00000073};
        run_to_halt();
        do_reset();

        // illegal opcode then a legal add
        prog_q = {32'h0000007F, 32'h002081B3, 32'h00000073};
        run_to_halt();
        do_reset();

        // three wait states per fetch; stop raised during the second fetch
        begin
            int budget;
            fixed_delay = 3;
            prog_q = {32'h002081B3, 32'h00308313, 32'h00000073};
            load_prog();
            n_fetch = 0; m_fetch = 0;
            model_run(2);
            lat_chk = 1'b1; lat_exp = 7;
            pulse_start();
            budget = 60;
            while (!(imem_req && imem_addr == 16'(RESET_PC + 16'd4)) && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("second_fetch_reached", imem_req, 1'b1);
            stop = 1'b1;
            budget = 60;
            while (busy && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            check("stop_idle_busy", busy, 1'b0);
            check("stop_pc", pc, m_pc);
            check("stop_fetches", n_fetch, 2);
            check("stop_scoreboard_empty", exp_q.size(), 0);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            check("stop_wins_busy", busy, 1'b0);
            check("stop_wins_req", imem_req, 1'b0);
            stop = 1'b0;
        end
        do_reset();

        // asynchronous reset during EXEC of the second instruction
        fixed_delay = 0;
        prog_q = {32'h002081B3, 32'h06408393, 32'h00000073};
        load_prog();
        n_fetch = 0; m_fetch = 0;
        model_run(1);
        pulse_start();
        while (cyc < start_cyc + 7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_we", rf_we, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_pc", pc, RESET_PC);
        check("arst_req", imem_req, 1'b0);
        check("arst_scoreboard_empty", exp_q.size(), 0);
        @(negedge clk);
        check("arst_we_held", rf_we, 1'b0);
        rst = 1'b0;
        model_reset();
        run_to_halt();
        do_reset();

        // randomized programs with random wait states; PC wraps past 0xFFFF
        fixed_delay = -1;
        for (int p = 0; p < 20; p++) begin
            int len;
            len = int'($urandom_range(3, 12));
            prog_q.delete();
            for (int i = 0; i < len; i++) prog_q.push_back(rand_instr());
            prog_q.push_back(32'h00000073);
            run_to_halt();
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle control sequencer for the decode/ALU datapath.
- Fetches a 32-bit instruction over a request/valid memory port, then splits it into register-file read addresses, the 14-bit ALU opcode and the destination address.
- Sequences operand read, ALU evaluation and register write-back, then advances the PC.
- Sits between instruction memory and the existing `regfile` and `alu` blocks; the ALU stays combinational and is driven by this block.

Parameters:
- N, 32, datapath width (ALU operands, result, register data).
- PC_W, 16, program-counter width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse; in IDLE, begins execution at the current PC.
- stop  input  1  level; finish the current instruction, then return to IDLE.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_W  fetch address (equals pc).
- imem_valid  input  1  fetch data valid.
- imem_rdata  input  32  fetched instruction.
- rf_raddr_a  output  5  source A address, ir[19:15].
- rf_raddr_b  output  5  source B address, ir[24:20].
- rf_rdata_a  input  N  register data A; registered read, one-cycle latency.
- rf_rdata_b  input  N  register data B; registered read, one-cycle latency.
- alu_a  output  N  ALU operand A.
- alu_b  output  N  ALU operand B.
- alu_op  output  14  {ir[31:25], ir[6:0]}.
- alu_result  input  N  combinational ALU result.
- rf_we  output  1  register write enable.
- rf_waddr  output  5  destination address, ir[11:7].
- rf_wdata  output  N  write-back data.
- pc  output  PC_W  current program counter.
- busy  output  1  high in any state except IDLE.
- illegal  output  1  sticky flag: an unsupported opcode was seen.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, ir=0. All outputs 0 except pc. Reset acts immediately, including mid-instruction: rf_we and imem_req drop without waiting for a clock edge.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: if start=1, go to FETCH; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc, held until imem_valid=1. imem_valid may assert in the same cycle as the request. On the edge where imem_req&&imem_valid, ir<=imem_rdata and go to DECODE. imem_valid outside FETCH is ignored.
- DECODE:
  - rf_raddr_a/b are driven from ir; read data is valid next cycle.
  - ir[6:0]=7'b1110011: go to HALT, no write-back.
  - ir[6:0] not in {0110011, 0010011, 1110011}: set illegal=1, skip to WB with write suppressed.
  - Otherwise go to EXEC.
- EXEC:
  - alu_a=rf_rdata_a.
  - alu_b=rf_rdata_b for opcode 0110011 (R-type).
  - alu_b=sign-extended ir[31:20] to N bits for 0010011 (I-type).
  - alu_op driven continuously from ir.
  - Result latched: res<=alu_result. Go to WB.
- WB:
  - rf_we=1 for exactly one cycle, with rf_waddr=ir[11:7] and rf_wdata=res.
  - rf_we is forced to 0 when rf_waddr=0 or the instruction was illegal.
  - pc<=pc+4, modulo 2^PC_W (wraps to 0 with no flag).
  - Next state: IDLE if stop=1, else FETCH.
- HALT: pc is not advanced; busy=1. Leaves only via rst; start is ignored.
- stop sampled in any state other than WB has no effect until WB. stop in IDLE keeps the block idle even if start=1 in the same cycle (stop wins).
- Minimum cost is 4 cycles per instruction; each FETCH wait cycle adds 1.
- alu_a/alu_b/rf_wdata hold their last values outside EXEC/WB. rf_we is 0 outside WB.

Optional Feature:
- Macro SEQ_RETIRE_CNT_EN.
- Defined: adds output retired [31:0].
  - Reset to 0.
  - Increments by 1 on every WB cycle of a legal instruction, whether or not the write is suppressed by rd=0.
  - Wraps at 2^32.
  - HALT and illegal instructions do not count.
- Undefined: no port, no counter logic. All other behaviour is identical.

Test Plan:
- Reset then start=1; imem_rdata=0x002081B3 (add x3,x1,x2), x1=5, x2=7, imem_valid same cycle -> alu_op={0x00,0x33}, rf_we=1 with waddr=3 and wdata=12 exactly 4 cycles after start; pc=4.
- Sequence of two instructions: addi x5,x0,-1 (0xFFF00293), then ecall (0x00000073) -> x5 written with all-ones; HALT entered with pc=4; later start pulses ignored; busy stays 1.
- Write to x0 (0x00208033) -> rf_we never asserted; pc advances to 4; retired=1 when SEQ_RETIRE_CNT_EN is defined.
- Illegal opcode 0x0000007F -> illegal=1 sticks; no rf_we; pc advances; next legal instruction executes normally.
- imem_valid delayed 3 cycles -> imem_req held steady with imem_addr=pc throughout; write-back at cycle 7; stop=1 during FETCH of the second instruction -> that instruction completes, then IDLE with busy=0.
- rst asserted during EXEC -> rf_we stays 0, state IDLE and pc=RESET_PC immediately; start afterwards refetches from RESET_PC.
